dsp_boot_sequencer: RTL and testbench
=====================================

// Module: dsp_boot_sequencer
// PURPOSE
//  Parametrised successor to the fixed DSP strap block. It drives boot-mode, bypass, NMI and ready
//  straps for NUM_DSP Blackfin DSPs and sequences their reset release: hold, then staggered release.
//  It monitors a per-DSP boot-complete flag with a timeout and issues timed NMI pulses at run time.
//  It sits between the cPCI-side control registers and the DSP strap/reset pins.
// PARAMETERS
//  NUM_DSP        2      number of DSPs controlled (1..8)
//  DEFAULT_BMODE  2'b11  BMODE driven after RESET (11 = SPI master boot)
//  HOLD_CYCLES    1000   cycles all DSP_RESETn held low with BMODE stable before first release (>=1)
//  STAGGER_CYCLES 100    cycles between successive DSP reset releases (>=1)
//  BOOT_TIMEOUT   2**20  cycles allowed in WAIT_BOOT before FAIL (>=1)
//  NMI_CYCLES     16     NMI pulse width in cycles (>=1)
// PORTS
//  CLK            in   1          system clock
//  RESET          in   1          synchronous, active-high reset
//  BOOT_START     in   1          one-cycle start/restart request
//  DSP_EN         in   NUM_DSP    DSPs to boot; sampled on accepted BOOT_START
//  BMODE_CFG      in   2*NUM_DSP  per-DSP BMODE[1:0] ({DSPn..DSP0}); sampled on accepted BOOT_START
//  DSP_BOOTED     in   NUM_DSP    boot-complete flag from each DSP (level, already synchronised)
//  NMI_REQ        in   NUM_DSP    one-cycle NMI request per DSP
//  NMI_CORE       in   1          0 = pulse NMI0 (core A), 1 = pulse NMI1 (core B); sampled with NMI_REQ
//  DSP_RESETn     out  NUM_DSP    active-low DSP reset
//  DSP_BMODE      out  2*NUM_DSP  boot-mode straps
//  DSP_BYPASS     out  NUM_DSP    PLL bypass strap, constant 1
//  DSP_NMI0       out  NUM_DSP    core A NMI
//  DSP_NMI1       out  NUM_DSP    core B NMI
//  DSP_BUS_READY  out  NUM_DSP    constant 1
//  DSP_ASYNC_READY out NUM_DSP    constant 1
//  BUSY           out  1          high in HOLD, RELEASE and WAIT_BOOT
//  DONE           out  1          high in RUN
//  BOOT_FAIL      out  NUM_DSP    enabled DSPs not booted at timeout; valid in FAIL
// BEHAVIOUR
//  Reset: state IDLE, DSP_RESETn=0, DSP_BMODE=DEFAULT_BMODE in every slot, NMI0/NMI1=0, BUSY=0,
//   DONE=0, BOOT_FAIL=0, all counters 0. BYPASS/READY outputs are 1 at all times.
//  States: IDLE, HOLD, RELEASE, WAIT_BOOT, RUN, FAIL. All outputs are registered.
//  IDLE: on BOOT_START, latch DSP_EN and BMODE_CFG, then go to HOLD next cycle. DSP_BMODE shows the
//   latched value from the HOLD entry cycle.
//  HOLD: all DSP_RESETn=0 for exactly HOLD_CYCLES cycles, then go to RELEASE with idx=0.
//  RELEASE: if en[idx] is set, DSP_RESETn[idx] rises on the first cycle in this slot and the FSM
//   waits STAGGER_CYCLES. If en[idx] is clear, the slot takes 1 cycle and that DSP stays in reset.
//   After idx=NUM_DSP-1 the FSM goes to WAIT_BOOT, with the timer cleared.
//  WAIT_BOOT: when (DSP_BOOTED & en)==en, go to RUN (DONE=1 next cycle). When the timer reaches
//   BOOT_TIMEOUT first, go to FAIL with BOOT_FAIL = en & ~DSP_BOOTED, captured on that cycle.
//   If both conditions hold on the same cycle, success wins. en==0 passes to RUN immediately.
//  RUN: DSP_RESETn stays at its released pattern. NMI_REQ[i] starts a NMI_CYCLES-wide pulse on
//   NMI0[i] or NMI1[i] (per NMI_CORE), starting the next cycle. Each DSP has its own pulse counter.
//   A request to a DSP whose pulse is already active is ignored. NMI_REQ outside RUN is ignored.
//  FAIL: holds BOOT_FAIL; released DSPs stay released; NMI inactive.
//  BOOT_START in RUN or FAIL restarts the boot: go to HOLD, all DSP_RESETn=0, NMI outputs forced
//   to 0, in-flight pulses aborted, DONE/BOOT_FAIL cleared. BOOT_START in HOLD, RELEASE or
//   WAIT_BOOT is ignored. BOOT_START together with NMI_REQ in RUN: the restart wins.
//  RESET at any time returns the block to the reset values on the next edge.
//  Counters are $clog2(max+1) bits wide and saturate; they do not wrap.
// TESTING (HOLD=8, STAGGER=4, TIMEOUT=50, NMI=3, NUM_DSP=2)
//  1 BOOT_START, EN=2'b11, CFG=4'b0111, BOOTED=11 after release -> BMODE=0111 for the whole of HOLD;
//    RESETn[0] rises 8 cycles after HOLD entry and RESETn[1] 4 cycles later; DONE=1.
//  2 EN=2'b10 -> RESETn[0] stays 0; RESETn[1] rises 9 cycles after HOLD entry; DONE when BOOTED[1]=1.
//  3 BOOTED[1] never set -> FAIL exactly 50 cycles after WAIT_BOOT entry; BOOT_FAIL=2'b10; DONE=0.
//  4 RUN, NMI_REQ=01, NMI_CORE=1 -> NMI1[0] high for 3 cycles; a repeat request mid-pulse is ignored;
//    NMI0 stays 0.
//  5 RUN with a pulse active, then BOOT_START -> NMI outputs 0 and RESETn=00 next cycle; HOLD restarts.
//  6 RESET asserted in RELEASE -> RESETn=00, BMODE=1111, BUSY=0 next cycle; BOOT_START is accepted again.

Source files
------------

// File: rtl/dsp_boot_sequencer.sv
// Strap driver and staggered reset-release sequencer for NUM_DSP Blackfin DSPs,
// with boot-complete timeout monitoring and per-DSP run-time NMI pulse generation.

module dsp_nmi_lane #(
    parameter int NMI_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic abort,
    input  logic req,
    input  logic core,
    output logic nmi0,
    output logic nmi1
);
    localparam int CNT_W = $clog2(NMI_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of pulse cycles already shown; new requests are dropped while active
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            nmi0 <= 1'b0;
            nmi1 <= 1'b0;
            cnt  <= '0;
        end else if (nmi0 || nmi1) begin
            if (cnt == CNT_W'(NMI_CYCLES)) begin
                nmi0 <= 1'b0;
                nmi1 <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (req) begin
            nmi0 <= ~core;
            nmi1 <= core;
            cnt  <= CNT_W'(1);
        end
    end
endmodule

module dsp_boot_sequencer #(
    parameter int         NUM_DSP        = 2,
    parameter logic [1:0] DEFAULT_BMODE  = 2'b11,
    parameter int         HOLD_CYCLES    = 1000,
    parameter int         STAGGER_CYCLES = 100,
    parameter int         BOOT_TIMEOUT   = 2**20,
    parameter int         NMI_CYCLES     = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BOOT_START,
    input  logic [NUM_DSP-1:0]     DSP_EN,
    input  logic [2*NUM_DSP-1:0]   BMODE_CFG,
    input  logic [NUM_DSP-1:0]     DSP_BOOTED,
    input  logic [NUM_DSP-1:0]     NMI_REQ,
    input  logic                   NMI_CORE,
    output logic [NUM_DSP-1:0]     DSP_RESETn,
    output logic [2*NUM_DSP-1:0]   DSP_BMODE,
    output logic [NUM_DSP-1:0]     DSP_BYPASS,
    output logic [NUM_DSP-1:0]     DSP_NMI0,
    output logic [NUM_DSP-1:0]     DSP_NMI1,
    output logic [NUM_DSP-1:0]     DSP_BUS_READY,
    output logic [NUM_DSP-1:0]     DSP_ASYNC_READY,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [NUM_DSP-1:0]     BOOT_FAIL
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
    localparam int TMO_W  = $clog2(BOOT_TIMEOUT + 1);
    localparam int IDX_W  = (NUM_DSP > 1) ? $clog2(NUM_DSP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_RELEASE, S_WAIT_BOOT, S_RUN, S_FAIL
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt, idx_inc;
    logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
    logic [STAG_W-1:0]    stag_cnt, stag_nxt;
    logic [TMO_W-1:0]     boot_tmr, tmr_nxt;
    logic [NUM_DSP-1:0]   en_q, en_nxt, resetn_q, resetn_nxt, fail_q, fail_nxt;
    logic [2*NUM_DSP-1:0] bmode_q, bmode_nxt;
    logic                 busy_q, done_q, start;
    logic                 nmi_abort;
    logic [NUM_DSP-1:0]   nmi_req_g;

    assign idx_inc = idx + IDX_W'(1);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        hold_nxt   = hold_cnt;
        stag_nxt   = stag_cnt;
        tmr_nxt    = boot_tmr;
        en_nxt     = en_q;
        resetn_nxt = resetn_q;
        bmode_nxt  = bmode_q;
        fail_nxt   = fail_q;
        start      = 1'b0;
        case (state)
            S_IDLE, S_RUN, S_FAIL: start = BOOT_START;
            S_HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_nxt     = S_RELEASE;
                    idx_nxt       = '0;
                    stag_nxt      = '0;
                    resetn_nxt[0] = en_q[0];
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            S_RELEASE: begin
                // a disabled slot costs one cycle; an enabled one waits out the stagger
                if (!en_q[idx] || stag_cnt == STAG_W'(STAGGER_CYCLES - 1)) begin
                    if (idx == IDX_W'(NUM_DSP - 1)) begin
                        state_nxt = S_WAIT_BOOT;
                        tmr_nxt   = '0;
                    end else begin
                        idx_nxt             = idx_inc;
                        stag_nxt            = '0;
                        resetn_nxt[idx_inc] = en_q[idx_inc];
                    end
                end else if (stag_cnt != '1) begin
                    stag_nxt = stag_cnt + STAG_W'(1);
                end
            end
            S_WAIT_BOOT: begin
                if ((DSP_BOOTED & en_q) == en_q) begin
                    state_nxt = S_RUN;
                end else if (boot_tmr == TMO_W'(BOOT_TIMEOUT - 1)) begin
                    state_nxt = S_FAIL;
                    fail_nxt  = en_q & ~DSP_BOOTED;
                end else if (boot_tmr != '1) begin
                    tmr_nxt = boot_tmr + TMO_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (start) begin
            state_nxt  = S_HOLD;
            hold_nxt   = '0;
            en_nxt     = DSP_EN;
            bmode_nxt  = BMODE_CFG;
            resetn_nxt = '0;
            fail_nxt   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            stag_cnt <= '0;
            boot_tmr <= '0;
            en_q     <= '0;
            resetn_q <= '0;
            bmode_q  <= {NUM_DSP{DEFAULT_BMODE}};
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            hold_cnt <= hold_nxt;
            stag_cnt <= stag_nxt;
            boot_tmr <= tmr_nxt;
            en_q     <= en_nxt;
            resetn_q <= resetn_nxt;
            bmode_q  <= bmode_nxt;
            fail_q   <= fail_nxt;
            busy_q   <= (state_nxt == S_HOLD) || (state_nxt == S_RELEASE) ||
                        (state_nxt == S_WAIT_BOOT);
            done_q   <= (state_nxt == S_RUN);
        end
    end

    // a restart in RUN beats any same-cycle NMI request and kills pulses in flight
    assign nmi_abort = (state == S_RUN) && BOOT_START;
    assign nmi_req_g = (state == S_RUN && !BOOT_START) ? NMI_REQ : '0;

    for (genvar i = 0; i < NUM_DSP; i++) begin : g_nmi
        dsp_nmi_lane #(.NMI_CYCLES(NMI_CYCLES)) u_nmi (
            .clk   (CLK),
            .rst   (RESET),
            .abort (nmi_abort),
            .req   (nmi_req_g[i]),
            .core  (NMI_CORE),
            .nmi0  (DSP_NMI0[i]),
            .nmi1  (DSP_NMI1[i])
        );
    end

    assign DSP_RESETn      = resetn_q;
    assign DSP_BMODE       = bmode_q;
    assign DSP_BYPASS      = '1;
    assign DSP_BUS_READY   = '1;
    assign DSP_ASYNC_READY = '1;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign BOOT_FAIL       = fail_q;
endmodule

// File: tb/tb_dsp_boot_sequencer.sv
// Directed bench for dsp_boot_sequencer: HOLD=8, STAGGER=4, TIMEOUT=50, NMI=3, two DSPs.

module tb_dsp_boot_sequencer;
    logic       CLK = 1'b0;
    logic       RESET, BOOT_START, NMI_CORE;
    logic [1:0] DSP_EN, DSP_BOOTED, NMI_REQ;
    logic [3:0] BMODE_CFG;
    logic [1:0] DSP_RESETn, DSP_BYPASS, DSP_NMI0, DSP_NMI1, DSP_BUS_READY, DSP_ASYNC_READY;
    logic [1:0] BOOT_FAIL;
    logic [3:0] DSP_BMODE;
    logic       BUSY, DONE;

    int tests = 0;
    int fails = 0;

    dsp_boot_sequencer #(
        .NUM_DSP(2), .DEFAULT_BMODE(2'b11), .HOLD_CYCLES(8), .STAGGER_CYCLES(4),
        .BOOT_TIMEOUT(50), .NMI_CYCLES(3)
    ) dut (
        .CLK(CLK), .RESET(RESET), .BOOT_START(BOOT_START), .DSP_EN(DSP_EN),
        .BMODE_CFG(BMODE_CFG), .DSP_BOOTED(DSP_BOOTED), .NMI_REQ(NMI_REQ),
        .NMI_CORE(NMI_CORE), .DSP_RESETn(DSP_RESETn), .DSP_BMODE(DSP_BMODE),
        .DSP_BYPASS(DSP_BYPASS), .DSP_NMI0(DSP_NMI0), .DSP_NMI1(DSP_NMI1),
        .DSP_BUS_READY(DSP_BUS_READY), .DSP_ASYNC_READY(DSP_ASYNC_READY),
        .BUSY(BUSY), .DONE(DONE), .BOOT_FAIL(BOOT_FAIL)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        RESET = 1'b1; BOOT_START = 1'b0; DSP_EN = 2'b00; BMODE_CFG = 4'b0000;
        DSP_BOOTED = 2'b00; NMI_REQ = 2'b00; NMI_CORE = 1'b0;
        tick(2);
        chk("rst_resetn", DSP_RESETn, 2'b00);
        chk("rst_bmode", DSP_BMODE, 4'b1111);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_fail", BOOT_FAIL, 2'b00);
        chk("rst_nmi", {DSP_NMI1, DSP_NMI0}, 4'b0000);
        chk("const_straps", {DSP_BYPASS, DSP_BUS_READY, DSP_ASYNC_READY}, 6'b111111);
        RESET = 1'b0;
        tick();
        chk("idle_busy", BUSY, 1'b0);

        // 1: both DSPs, staggered release then boot
        BOOT_START = 1'b1; DSP_EN = 2'b11; BMODE_CFG = 4'b0111;
        tick();
        BOOT_START = 1'b0;
        chk("t1_h0_bmode", DSP_BMODE, 4'b0111);
        chk("t1_h0_busy", BUSY, 1'b1);
        chk("t1_h0_resetn", DSP_RESETn, 2'b00);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t1_hold_resetn", DSP_RESETn, 2'b00);
            chk("t1_hold_bmode", DSP_BMODE, 4'b0111);
        end
        tick();
        chk("t1_h8_resetn", DSP_RESETn, 2'b01);
        tick(3);
        chk("t1_h11_resetn", DSP_RESETn, 2'b01);
        DSP_BOOTED = 2'b11;
        tick();
        chk("t1_h12_resetn", DSP_RESETn, 2'b11);
        tick(4);
        chk("t1_wait_busy", BUSY, 1'b1);
        chk("t1_wait_done", DONE, 1'b0);
        tick();
        chk("t1_done", DONE, 1'b1);
        chk("t1_run_busy", BUSY, 1'b0);

        // 4: NMI on core B of DSP0, repeat mid-pulse dropped
        NMI_REQ = 2'b01; NMI_CORE = 1'b1;
        tick();
        NMI_REQ = 2'b00;
        chk("t4_n1_nmi1", DSP_NMI1, 2'b01);
        chk("t4_n1_nmi0", DSP_NMI0, 2'b00);
        tick();
        chk("t4_n2_nmi1", DSP_NMI1, 2'b01);
        NMI_REQ = 2'b01; NMI_CORE = 1'b0;
        tick();
        NMI_REQ = 2'b00;
        chk("t4_n3_nmi1", DSP_NMI1, 2'b01);
        chk("t4_n3_nmi0", DSP_NMI0, 2'b00);
        tick();
        chk("t4_n4_nmi", {DSP_NMI1, DSP_NMI0}, 4'b0000);

        // 5: restart while a pulse is active; also starts test 2 (EN=10)
        NMI_REQ = 2'b10; NMI_CORE = 1'b0;
        tick();
        NMI_REQ = 2'b00;
        chk("t5_pulse_nmi0", DSP_NMI0, 2'b10);
        DSP_BOOTED = 2'b00;
        BOOT_START = 1'b1; DSP_EN = 2'b10; BMODE_CFG = 4'b1001;
        tick();
        BOOT_START = 1'b0;
        chk("t5_abort_nmi", {DSP_NMI1, DSP_NMI0}, 4'b0000);
        chk("t5_resetn", DSP_RESETn, 2'b00);
        chk("t5_done", DONE, 1'b0);
        chk("t5_busy", BUSY, 1'b1);
        chk("t5_bmode", DSP_BMODE, 4'b1001);
        tick();
        chk("t5_h1_nmi", {DSP_NMI1, DSP_NMI0}, 4'b0000);

        // 2: DSP0 disabled, its slot takes one cycle
        tick(7);
        chk("t2_h8_resetn", DSP_RESETn, 2'b00);
        tick();
        chk("t2_h9_resetn", DSP_RESETn, 2'b10);
        tick(6);
        chk("t2_wait_done", DONE, 1'b0);
        chk("t2_wait_busy", BUSY, 1'b1);
        DSP_BOOTED = 2'b10;
        tick();
        chk("t2_done", DONE, 1'b1);
        chk("t2_run_resetn", DSP_RESETn, 2'b10);

        // 3: DSP1 never boots; BOOTED[0] is outside EN and must be masked
        DSP_BOOTED = 2'b01;
        BOOT_START = 1'b1; DSP_EN = 2'b10; BMODE_CFG = 4'b1111;
        tick();
        BOOT_START = 1'b0;
        tick(13);
        chk("t3_w0_busy", BUSY, 1'b1);
        tick(49);
        chk("t3_w49_busy", BUSY, 1'b1);
        chk("t3_w49_fail", BOOT_FAIL, 2'b00);
        tick();
        chk("t3_fail_busy", BUSY, 1'b0);
        chk("t3_fail_vec", BOOT_FAIL, 2'b10);
        chk("t3_fail_done", DONE, 1'b0);
        chk("t3_fail_resetn", DSP_RESETn, 2'b10);
        NMI_REQ = 2'b11; NMI_CORE = 1'b1;
        tick();
        NMI_REQ = 2'b00;
        chk("t3_fail_nmi", {DSP_NMI1, DSP_NMI0}, 4'b0000);

        // 6: restart from FAIL, ignored start in HOLD, then RESET in RELEASE
        BOOT_START = 1'b1; DSP_EN = 2'b11; BMODE_CFG = 4'b0000;
        tick();
        BOOT_START = 1'b0;
        chk("t6_fail_clr", BOOT_FAIL, 2'b00);
        tick(3);
        BOOT_START = 1'b1; BMODE_CFG = 4'b0101;
        tick();
        BOOT_START = 1'b0;
        chk("t6_hold_ignore_bmode", DSP_BMODE, 4'b0000);
        tick(4);
        chk("t6_h8_resetn", DSP_RESETn, 2'b01);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("t6_rst_resetn", DSP_RESETn, 2'b00);
        chk("t6_rst_bmode", DSP_BMODE, 4'b1111);
        chk("t6_rst_busy", BUSY, 1'b0);
        BOOT_START = 1'b1; DSP_EN = 2'b01; BMODE_CFG = 4'b0010;
        tick();
        BOOT_START = 1'b0;
        chk("t6_restart_busy", BUSY, 1'b1);
        chk("t6_restart_bmode", DSP_BMODE, 4'b0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
